ex_mem_stage: RTL and testbench

- Pipeline register and elastic buffer between the execute stage (ALU result) and the memory/writeback stage.
- Captures the ALU result, opcode, destination register index and store data with a valid/ready handshake.
- Holds up to two entries as a skid buffer, so backpressure never combinationally reaches the execute stage.
- Pre-decodes the opcode into memory-read, memory-write and register-writeback controls for the downstream stage.

---
 rtl/ex_mem_stage.sv | 115 +++++++++++
 tb/tb_ex_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a two-entry skid buffer and opcode pre-decode.
// Define EX_MEM_FWD_EN to add the fwd_valid_o/fwd_rd_o/fwd_data_o bypass outputs.
`ifndef ADD_OP
`define ADD_OP 4'h0
`define SUB_OP 4'h1
`define MUL_OP 4'h2
`define DIV_OP 4'h3
`define AND_OP 4'h4
`define OR_OP  4'h5
`define XOR_OP 4'h6
`define LW_OP  4'h7
`define SW_OP  4'h8
`define LI_OP  4'h9
`define BEQ_OP 4'hA
`define BGT_OP 4'hB
`define BGE_OP 4'hC
`define JMP_OP 4'hD
`endif

module ex_mem_stage #(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATAWIDTH-1:0] alu_out_i,
    input  logic [3:0]           opcode_i,
    input  logic [REGADDR-1:0]   rd_i,
    input  logic [DATAWIDTH-1:0] store_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] result_o,
    output logic [DATAWIDTH-1:0] store_data_o,
    output logic [REGADDR-1:0]   rd_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic                 wb_en_o
`ifdef EX_MEM_FWD_EN
    ,
    output logic                 fwd_valid_o,
    output logic [REGADDR-1:0]   fwd_rd_o,
    output logic [DATAWIDTH-1:0] fwd_data_o
`endif
);
    typedef struct packed {
        logic [DATAWIDTH-1:0] result;
        logic [DATAWIDTH-1:0] sdata;
        logic [REGADDR-1:0]   rd;
        logic                 mem_rd;
        logic                 mem_wr;
        logic                 wb_en;
    } entry_t;

    entry_t main_q, skid_q, in_entry;
    logic   main_valid, skid_valid, in_fire, out_fire, wb_op;

    assign wb_op = opcode_i inside {`ADD_OP, `SUB_OP, `MUL_OP, `DIV_OP, `AND_OP,
                                    `OR_OP, `XOR_OP, `LW_OP, `LI_OP};

    always_comb begin
        in_entry        = '0;
        in_entry.result = alu_out_i;
        in_entry.sdata  = store_data_i;
        in_entry.rd     = rd_i;
        in_entry.mem_rd = opcode_i == `LW_OP;
        in_entry.mem_wr = opcode_i == `SW_OP;
        in_entry.wb_en  = wb_op && (rd_i != '0);
    end

    // Ready comes straight from the skid flop, so out_ready_i never reaches in_ready_o.
    assign in_ready_o = ~skid_valid;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = main_valid && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_fire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire) main_q <= in_entry;
            end
        end else if (in_fire) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid_o  = main_valid;
    assign result_o     = main_q.result;
    assign store_data_o = main_q.sdata;
    assign rd_o         = main_q.rd;
    assign mem_rd_o     = main_valid && main_q.mem_rd;
    assign mem_wr_o     = main_valid && main_q.mem_wr;
    assign wb_en_o      = main_valid && main_q.wb_en;

`ifdef EX_MEM_FWD_EN
    assign fwd_valid_o = out_valid_o && wb_en_o && !mem_rd_o;
    assign fwd_rd_o    = rd_o;
    assign fwd_data_o  = result_o;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed self-checking bench for ex_mem_stage.
`timescale 1ns/1ps
`ifndef ADD_OP
`define ADD_OP 4'h0
`define SUB_OP 4'h1
`define MUL_OP 4'h2
`define DIV_OP 4'h3
`define AND_OP 4'h4
`define OR_OP  4'h5
`define XOR_OP 4'h6
`define LW_OP  4'h7
`define SW_OP  4'h8
`define LI_OP  4'h9
`define BEQ_OP 4'hA
`define BGT_OP 4'hB
`define BGE_OP 4'hC
`define JMP_OP 4'hD
`endif

module tb_ex_mem_stage;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] alu_out = '0, store_data = '0, result, sdata_out;
    logic [3:0]  opcode = '0;
    logic [4:0]  rd = '0, rd_out;
    logic        mem_rd, mem_wr, wb_en;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif
    int n_cmp = 0, n_bad = 0;

    ex_mem_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .alu_out_i(alu_out), .opcode_i(opcode), .rd_i(rd), .store_data_i(store_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .store_data_o(sdata_out), .rd_o(rd_out),
        .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .wb_en_o(wb_en)
`ifdef EX_MEM_FWD_EN
        , .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [4:0] r);
        in_valid = v; opcode = op; alu_out = a; rd = r; store_data = a ^ 32'hFFFF_0000;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_wb_en", wb_en, 0);
        #10 rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        drive(1, `ADD_OP, 32'h10, 5'd3);
        step();
        chk("single_valid", out_valid, 1);
        chk("single_result", result, 32'h10);
        chk("single_rd", rd_out, 3);
        chk("single_sdata", sdata_out, 32'hFFFF_0010);
        chk("single_wb", wb_en, 1);
        chk("single_mrd", mem_rd, 0);
        chk("single_mwr", mem_wr, 0);
        drive(0, `ADD_OP, 0, 0);
        step();
        chk("single_drain", out_valid, 0);

        out_ready = 1'b0;
        drive(1, `ADD_OP, 32'h1, 5'd1);
        step();
        chk("bp_A_main", result, 1);
        chk("bp_ready_after_A", in_ready, 1);
        drive(1, `ADD_OP, 32'h2, 5'd1);
        step();
        chk("bp_ready_after_B", in_ready, 0);
        drive(1, `ADD_OP, 32'h3, 5'd1);
        step();
        chk("bp_stall_result", result, 1);
        chk("bp_stall_ready", in_ready, 0);
        step();
        chk("bp_stable_result", result, 1);
        chk("bp_stable_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("bp_out_B", result, 2);
        chk("bp_ready_again", in_ready, 1);
        step();
        chk("bp_out_C", result, 3);
        drive(0, `ADD_OP, 0, 0);
        step();
        chk("bp_drained", out_valid, 0);

        drive(1, `LW_OP, 32'h100, 5'd5);
        step();
        chk("lw_mrd", mem_rd, 1);
        chk("lw_wb", wb_en, 1);
        chk("lw_mwr", mem_wr, 0);
        drive(1, `SW_OP, 32'h104, 5'd6);
        step();
        chk("sw_mwr", mem_wr, 1);
        chk("sw_wb", wb_en, 0);
        chk("sw_sdata", sdata_out, 32'hFFFF_0104);
        drive(1, `BEQ_OP, 32'h8, 5'd2);
        step();
        chk("beq_flags", {mem_rd, mem_wr, wb_en}, 0);
        chk("beq_valid", out_valid, 1);
        drive(1, `ADD_OP, 32'h9, 5'd0);
        step();
        chk("add_r0_wb", wb_en, 0);
        drive(1, 4'hF, 32'hA, 5'd4);
        step();
        chk("undef_flags", {mem_rd, mem_wr, wb_en}, 0);
        chk("undef_result", result, 32'hA);
        drive(1, `LI_OP, 32'hB, 5'd4);
        step();
        chk("li_wb", wb_en, 1);
        drive(0, `ADD_OP, 0, 0);
        step();
        chk("dec_flags_empty", {mem_rd, mem_wr, wb_en}, 0);

        out_ready = 1'b0;
        drive(1, `ADD_OP, 32'h11, 5'd1);
        step();
        drive(1, `ADD_OP, 32'h22, 5'd1);
        step();
        chk("fl_full_ready", in_ready, 0);
        flush = 1'b1;
        drive(1, `ADD_OP, 32'h44, 5'd1);
        step();
        flush = 1'b0;
        drive(0, `ADD_OP, 0, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", out_valid, 0);
        drive(1, `ADD_OP, 32'h55, 5'd1);
        step();
        flush = 1'b1;
        drive(1, `ADD_OP, 32'h66, 5'd1);
        step();
        flush = 1'b0;
        drive(0, `ADD_OP, 0, 0);
        chk("fl_push_dropped", out_valid, 0);
        step();
        chk("fl_push_never", out_valid, 0);

        out_ready = 1'b0;
        drive(1, `ADD_OP, 32'h77, 5'd1);
        step();
        drive(1, `ADD_OP, 32'h88, 5'd1);
        step();
        drive(0, `ADD_OP, 0, 0);
        chk("ar_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_async", out_valid, 0);
        chk("ar_ready_async", in_ready, 1);
        #1 rst_n = 1'b1;
        drive(1, `ADD_OP, 32'h99, 5'd4);
        step();
        chk("ar_new_valid", out_valid, 1);
        chk("ar_new_result", result, 32'h99);
        drive(0, `ADD_OP, 0, 0);
        out_ready = 1'b1;
        step();
        chk("ar_old_gone", out_valid, 0);

`ifdef EX_MEM_FWD_EN
        drive(1, `XOR_OP, 32'hDEADBEEF, 5'd7);
        step();
        chk("fwd_xor_valid", fwd_valid, 1);
        chk("fwd_xor_rd", fwd_rd, 7);
        chk("fwd_xor_data", fwd_data, 32'hDEADBEEF);
        drive(1, `LW_OP, 32'h200, 5'd7);
        step();
        chk("fwd_lw_valid", fwd_valid, 0);
        drive(0, `ADD_OP, 0, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
